// File: rtl/csp_pkg.sv
// Shared types and constants for the CSP rendezvous channel.
package csp_pkg;

  typedef enum logic {
    P4PhaseBD,
    P2PhaseBD
  } hs_protocol_e;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    RETURN
  } chan_state_e;

  localparam int unsigned NOC_PKT_WIDTH = 57;

  function automatic logic is_two_phase(input hs_protocol_e p);
    return (p == P2PhaseBD);
  endfunction

endpackage

// File: rtl/csp_channel_if.sv
// Sender/receiver bundle of a CSP channel; master is the channel's own view, slave the environment's.
interface csp_channel_if #(
  parameter int unsigned WIDTH = 8
);
  logic             s_req;
  logic [WIDTH-1:0] s_data;
  logic             s_ack;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;
  logic             probe;
  logic [31:0]      xfer_count;
  logic             proto_err;

  modport master (
    input  s_req, s_data, r_ack,
    output s_ack, r_req, r_data, probe, xfer_count, proto_err
  );

  modport slave (
    output s_req, s_data, r_ack,
    input  s_ack, r_req, r_data, probe, xfer_count, proto_err
  );
endinterface

// File: rtl/csp_req_sync.sv
// Flop chain for a single handshake line; zero stages gives a plain wire.
module csp_req_sync #(
  parameter int unsigned STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic sync_unused;
      assign sync_unused = clk ^ rst;
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] chain_q;
      logic [STAGES-1:0] chain_d;

      assign chain_d[0] = d;
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        assign chain_d[gi] = chain_q[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_q <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign q = chain_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/csp_channel.sv
// Single-slot CSP rendezvous channel: the sender is acknowledged only after the receiver accepts the token.
module csp_channel
  import csp_pkg::*;
#(
  parameter int unsigned  WIDTH       = 8,
  parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD,
  parameter int unsigned  SYNC_STAGES = 0
) (
  input logic           clk,
  input logic           rst,
  csp_channel_if.master bus
);

  localparam bit TWO_PH = is_two_phase(HS_PROTOCOL);

  logic s_req_s;
  logic r_ack_s;

  csp_req_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (bus.s_req),
    .q   (s_req_s)
  );

  csp_req_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (bus.r_ack),
    .q   (r_ack_s)
  );

  chan_state_e      state_q, state_d;
  logic             r_req_q, r_req_d;
  logic             s_ack_q, s_ack_d;
  logic             probe_q, probe_d;
  logic             err_q, err_d;
  logic             r_ack_prev_q;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic [31:0]      count_q, count_d;

  logic req_ev;
  logic ack_ev;
  logic ack_spurious;

  // In 2-phase the output lines double as phase registers: s_ack holds the
  // last acknowledged request phase, r_req the phase the receiver must match.
  always_comb begin
    if (TWO_PH) begin
      req_ev       = (s_req_s != s_ack_q);
      ack_ev       = (r_ack_s == r_req_q);
      ack_spurious = (r_ack_s != r_req_q);
    end else begin
      req_ev       = s_req_s;
      ack_ev       = r_ack_s;
      ack_spurious = r_ack_s & ~r_ack_prev_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_req_d  = r_req_q;
    s_ack_d  = s_ack_q;
    r_data_d = r_data_q;
    count_d  = count_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_ev) begin
          r_data_d = bus.s_data;
          r_req_d  = TWO_PH ? ~r_req_q : 1'b1;
          state_d  = OFFER;
        end else if (ack_spurious) begin
          err_d = 1'b1;
        end
      end
      OFFER: begin
        if (!TWO_PH && !s_req_s) begin
          err_d = 1'b1;
        end
        if (ack_ev) begin
          s_ack_d = TWO_PH ? ~s_ack_q : 1'b1;
          if (!TWO_PH) begin
            r_req_d = 1'b0;
          end
          count_d = count_q + 32'd1;
          state_d = RETURN;
        end
      end
      RETURN: begin
        if (TWO_PH) begin
          state_d = IDLE;
        end else if (!s_req_s && !r_ack_s) begin
          s_ack_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    probe_d = (state_d == OFFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      r_req_q      <= 1'b0;
      s_ack_q      <= 1'b0;
      probe_q      <= 1'b0;
      err_q        <= 1'b0;
      r_ack_prev_q <= 1'b0;
      r_data_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      r_req_q      <= r_req_d;
      s_ack_q      <= s_ack_d;
      probe_q      <= probe_d;
      err_q        <= err_d;
      r_ack_prev_q <= r_ack_s;
      r_data_q     <= r_data_d;
      count_q      <= count_d;
    end
  end

  assign bus.s_ack      = s_ack_q;
  assign bus.r_req      = r_req_q;
  assign bus.r_data     = r_data_q;
  assign bus.probe      = probe_q;
  assign bus.xfer_count = count_q;
  assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_csp_channel.sv
// Bench for csp_channel: 4-phase vector table, reset/2-phase/sync-latency sequences, random token stream.
module tb_csp_channel;
  import csp_pkg::*;

  localparam int LIM  = 100;
  localparam int NTOK = 441;
  localparam int NV   = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csp_channel_if #(.WIDTH(57)) b4 ();
  csp_channel_if #(.WIDTH(8))  b2 ();
  csp_channel_if #(.WIDTH(13)) bs ();

  csp_channel #(.WIDTH(57), .HS_PROTOCOL(P4PhaseBD), .SYNC_STAGES(0)) u4 (.clk(clk), .rst(rst), .bus(b4));
  csp_channel #(.WIDTH(8),  .HS_PROTOCOL(P2PhaseBD), .SYNC_STAGES(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  csp_channel #(.WIDTH(13), .HS_PROTOCOL(P4PhaseBD), .SYNC_STAGES(2)) us (.clk(clk), .rst(rst), .bus(bs));

  int checks = 0;
  int errors = 0;
  bit abort  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_true(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      abort = 1'b1;
      $display("FAIL %s actual=timeout required=event within %0d cycles", name, LIM);
    end
  endtask

  // Toggle counters for the 2-phase lines
  logic r2_prev = 1'b0, s2_prev = 1'b0;
  int   r2_tog = 0, s2_tog = 0;
  always @(negedge clk) begin
    r2_prev <= b2.r_req;
    s2_prev <= b2.s_ack;
    if (b2.r_req !== r2_prev) r2_tog <= r2_tog + 1;
    if (b2.s_ack !== s2_prev) s2_tog <= s2_tog + 1;
  end

  typedef struct {
    logic        s_req;
    logic        r_ack;
    logic [56:0] s_data;
    logic        r_req;
    logic        s_ack;
    logic        probe;
    logic [56:0] r_data;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t vecs[NV];
  logic [12:0] exp_q[$];

  initial begin
    logic [56:0] d0;
    logic [56:0] d1;
    logic        prev;
    int          n;

    d0 = 57'h1ABCDEF0123456;
    d1 = 57'h155;
    //            s_req r_ack s_data  r_req s_ack probe r_data cnt err
    vecs[0]  = '{1'b1, 1'b0, d0, 1'b1, 1'b0, 1'b1, d0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, d0, 1'b1, 1'b0, 1'b1, d0, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, d0, 1'b0, 1'b1, 1'b0, d0, 1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, d0, 1'b0, 1'b1, 1'b0, d0, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, d0, 1'b0, 1'b1, 1'b0, d0, 1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, d0, 1'b0, 1'b0, 1'b0, d0, 1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, d1, 1'b1, 1'b0, 1'b1, d1, 1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, d1, 1'b1, 1'b0, 1'b1, d1, 1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, d1, 1'b1, 1'b0, 1'b1, d1, 1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, d1, 1'b0, 1'b1, 1'b0, d1, 2, 1'b1};
    vecs[10] = '{1'b0, 1'b0, d1, 1'b0, 1'b0, 1'b0, d1, 2, 1'b1};

    b4.s_req = 0; b4.r_ack = 0; b4.s_data = '0;
    b2.s_req = 0; b2.r_ack = 0; b2.s_data = '0;
    bs.s_req = 0; bs.r_ack = 0; bs.s_data = '0;

    repeat (3) @(negedge clk);
    check("rst_r_req", b4.r_req, 0);
    check("rst_s_ack", b4.s_ack, 0);
    check("rst_probe", b4.probe, 0);
    check("rst_r_data", b4.r_data, 0);
    check("rst_count", b4.xfer_count, 0);
    check("rst_err", b4.proto_err, 0);
    rst = 1'b0;

    // 4-phase vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      b4.s_req = vecs[i].s_req; b4.r_ack = vecs[i].r_ack; b4.s_data = vecs[i].s_data;
      @(posedge clk); #1;
      check($sformatf("vec%0d_r_req", i),  b4.r_req, vecs[i].r_req);
      check($sformatf("vec%0d_s_ack", i),  b4.s_ack, vecs[i].s_ack);
      check($sformatf("vec%0d_probe", i),  b4.probe, vecs[i].probe);
      check($sformatf("vec%0d_r_data", i), b4.r_data, vecs[i].r_data);
      check($sformatf("vec%0d_count", i),  b4.xfer_count, 64'(vecs[i].cnt));
      check($sformatf("vec%0d_err", i),    b4.proto_err, vecs[i].err);
    end

    // Reset while offering: outputs clear without waiting for a clock edge
    @(negedge clk); b4.s_req = 1; b4.s_data = 57'h0AA55;
    @(negedge clk);
    check("mid_offer_r_req", b4.r_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_r_req", b4.r_req, 0);
    check("async_rst_s_ack", b4.s_ack, 0);
    check("async_rst_probe", b4.probe, 0);
    check("async_rst_r_data", b4.r_data, 0);
    check("async_rst_err", b4.proto_err, 0);
    b4.s_req = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); b4.s_req = 1; b4.s_data = 57'h123;
    @(posedge clk); #1;
    check("post_rst_r_data", b4.r_data, 57'h123);
    check("post_rst_r_req", b4.r_req, 1);
    @(negedge clk); b4.r_ack = 1;
    @(posedge clk); #1;
    check("post_rst_s_ack", b4.s_ack, 1);
    check("post_rst_count", b4.xfer_count, 1);
    @(negedge clk); b4.s_req = 0; b4.r_ack = 0;
    @(posedge clk); #1;
    check("post_rst_release", b4.s_ack, 0);
    check("post_rst_err", b4.proto_err, 0);

    // Receiver ack with nothing offered
    @(negedge clk); b4.r_ack = 1;
    @(posedge clk); #1;
    check("idle_ack_err", b4.proto_err, 1);
    @(negedge clk); b4.r_ack = 0;
    repeat (2) @(negedge clk);
    check("idle_ack_err_sticky", b4.proto_err, 1);
    check("idle_ack_no_xfer", b4.xfer_count, 1);

    // 2-phase: three transfers with an immediate receiver
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      b2.s_data = 8'(8'hA0 + t);
      b2.s_req  = ~b2.s_req;
      prev = b2.r_req;
      n = 0;
      while (b2.r_req === prev && n < LIM) begin @(negedge clk); n++; end
      expect_true($sformatf("p2_offer%0d", t), n < LIM);
      check($sformatf("p2_data%0d", t), b2.r_data, 64'(8'hA0 + t));
      check($sformatf("p2_probe%0d", t), b2.probe, 1);
      prev = b2.s_ack;
      b2.r_ack = ~b2.r_ack;
      n = 0;
      while (b2.s_ack === prev && n < LIM) begin @(negedge clk); n++; end
      expect_true($sformatf("p2_ack%0d", t), n < LIM);
    end
    repeat (4) @(negedge clk);
    check("p2_r_req_toggles", 64'(r2_tog), 3);
    check("p2_s_ack_toggles", 64'(s2_tog), 3);
    check("p2_count", b2.xfer_count, 3);
    check("p2_err", b2.proto_err, 0);

    // Two synchronizer stages: forward latency of three cycles
    @(negedge clk); bs.s_req = 1; bs.s_data = 13'h1A5;
    @(posedge clk); #1; check("sync_lat_c1", bs.r_req, 0);
    @(posedge clk); #1; check("sync_lat_c2", bs.r_req, 0);
    @(posedge clk); #1; check("sync_lat_c3", bs.r_req, 1);
    check("sync_lat_data", bs.r_data, 13'h1A5);
    @(negedge clk); bs.r_ack = 1;
    n = 0;
    while (bs.s_ack !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    expect_true("sync_ack", n < LIM);
    bs.s_req = 0; bs.r_ack = 0;
    n = 0;
    while (bs.s_ack !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    expect_true("sync_release", n < LIM);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Random-delay stream of 441 tokens through the synchronized channel
    fork
      begin : sender
        int m;
        for (int i = 0; i < NTOK && !abort; i++) begin
          @(negedge clk);
          bs.s_data = 13'(i);
          bs.s_req  = 1'b1;
          exp_q.push_back(13'(i));
          m = 0;
          while (bs.s_ack !== 1'b1 && m < LIM && !abort) begin @(negedge clk); m++; end
          if (m >= LIM) expect_true($sformatf("rnd_sack_rise%0d", i), 1'b0);
          bs.s_req = 1'b0;
          m = 0;
          while (bs.s_ack !== 1'b0 && m < LIM && !abort) begin @(negedge clk); m++; end
          if (m >= LIM) expect_true($sformatf("rnd_sack_fall%0d", i), 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : receiver
        int          m;
        logic [12:0] exp_tok;
        for (int k = 0; k < NTOK && !abort; k++) begin
          m = 0;
          while (bs.r_req !== 1'b1 && m < LIM && !abort) begin @(negedge clk); m++; end
          if (m >= LIM) expect_true($sformatf("rnd_offer%0d", k), 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          exp_tok = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
          check($sformatf("rnd_token%0d", k), bs.r_data, exp_tok);
          bs.r_ack = 1'b1;
          m = 0;
          while (bs.r_req !== 1'b0 && m < LIM && !abort) begin @(negedge clk); m++; end
          if (m >= LIM) expect_true($sformatf("rnd_rreq_fall%0d", k), 1'b0);
          bs.r_ack = 1'b0;
        end
      end
    join

    repeat (8) @(negedge clk);
    check("rnd_count", bs.xfer_count, NTOK);
    check("rnd_leftover", 64'(exp_q.size()), 0);
    check("rnd_err", bs.proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
